// File: rtl/mem_arbiter_pkg.sv
// Shared access codes, sizing defaults and FSM states
// for the two-port external memory arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] ACC_READ  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;
  localparam logic [1:0] ACC_BURST = 2'b10;

  localparam int DEF_MAX_BURST = 320;
  localparam int DEF_HR_AW     = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WORD,
    S_BURST,
    S_ACK
  } arb_state_e;

  function automatic logic [8:0] clamp_burst(
    input logic [8:0] b,
    input logic [8:0] lim
  );
    return (b > lim) ? lim : b;
  endfunction

endpackage

// File: rtl/mem_arbiter_burst_writer.sv
// Burst word counter and address stepper; streams each
// returned word into the high-RAM line buffer.
module mem_arbiter_burst_writer
  import mem_arbiter_pkg::*;
#(
  parameter int HR_AW = DEF_HR_AW
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [8:0]       len,
  input  logic             word_ack,
  input  logic [15:0]      rdata,
  output logic [31:0]      addr,
  output logic             empty,
  output logic             last,
  output logic [HR_AW-1:0] high_ram_addr,
  output logic [15:0]      high_ram_din,
  output logic             high_ram_wr
);

  logic [8:0] k;
  logic [8:0] len_q;

  always_ff @(posedge clk) begin
    if (res) begin
      k             <= '0;
      len_q         <= '0;
      addr          <= '0;
      high_ram_addr <= '0;
      high_ram_din  <= '0;
      high_ram_wr   <= 1'b0;
    end else begin
      high_ram_wr <= word_ack;
      if (start) begin
        k     <= '0;
        len_q <= len;
        addr  <= base;
      end else if (word_ack) begin
        k             <= k + 9'd1;
        addr          <= addr + 32'd1;
        high_ram_addr <= HR_AW'(k);
        high_ram_din  <= rdata;
      end
    end
  end

  assign empty = (len_q == 9'd0);
  assign last  = (k + 9'd1 == len_q);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 0 (video) has fixed
// priority, port 1 (CPU) is served when port 0 is idle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int HR_AW     = DEF_HR_AW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             res,
  input  logic [31:0]      rq0_addr,
  input  logic             rq0_cs,
  input  logic [1:0]       rq0_acc,
  input  logic [8:0]       rq0_burst,
  input  logic [31:0]      rq0_din,
  output logic [31:0]      rq0_dout,
  output logic             rq0_ack,
  input  logic [31:0]      rq1_addr,
  input  logic             rq1_cs,
  input  logic [1:0]       rq1_acc,
  input  logic [8:0]       rq1_burst,
  input  logic [31:0]      rq1_din,
  output logic [31:0]      rq1_dout,
  output logic             rq1_ack,
  output logic             ram_req,
  output logic             ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  input  logic             ram_ack,
  output logic [HR_AW-1:0] high_ram_addr,
  output logic [15:0]      high_ram_din,
  output logic             high_ram_wr,
  output logic [1:0]       ovf
);

  arb_state_e state, state_n;

  logic [1:0] cs, pend, active, take, want;
  logic [1:0] gmask, ovf_q;

  logic [1:0][31:0] in_addr, q_addr, eff_addr;
  logic [1:0][31:0] in_din, q_din, eff_din;
  logic [1:0][1:0]  in_acc, q_acc, eff_acc;
  logic [1:0][8:0]  in_burst, q_burst, eff_burst;

  logic        gport, gsel, grant;
  logic        req_n, rd_done;
  logic [1:0]  g_acc;
  logic [8:0]  g_len, bw_len;
  logic [31:0] word_addr, bw_addr;
  logic        bw_start, bw_ack;
  logic        bw_empty, bw_last;

  assign cs       = {rq1_cs, rq0_cs};
  assign in_addr  = {rq1_addr, rq0_addr};
  assign in_din   = {rq1_din, rq0_din};
  assign in_acc   = {rq1_acc, rq0_acc};
  assign in_burst = {rq1_burst, rq0_burst};

  assign active = (state == S_IDLE) ? 2'b00 :
                  (gport ? 2'b10 : 2'b01);
  assign take   = cs & ~pend & ~active;
  assign want   = pend | take;

  // A cs in the grant cycle bypasses its own latch.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      eff_addr[p]  = pend[p] ? q_addr[p]  : in_addr[p];
      eff_din[p]   = pend[p] ? q_din[p]   : in_din[p];
      eff_acc[p]   = pend[p] ? q_acc[p]   : in_acc[p];
      eff_burst[p] = pend[p] ? q_burst[p] : in_burst[p];
    end
  end

  assign gsel  = ~want[0];
  assign g_acc = eff_acc[gsel];
  assign g_len = clamp_burst(eff_burst[gsel],
                             9'(MAX_BURST));
  assign bw_len = (g_acc == ACC_BURST) ? g_len : 9'd0;

  always_comb begin
    state_n  = state;
    req_n    = ram_req;
    grant    = 1'b0;
    bw_start = 1'b0;
    rd_done  = 1'b0;
    unique case (state)
      S_IDLE, S_ACK: begin
        state_n = S_IDLE;
        req_n   = 1'b0;
        if (|want) begin
          grant = 1'b1;
          unique case (g_acc)
            ACC_READ, ACC_WRITE: begin
              state_n = S_WORD;
              req_n   = 1'b1;
            end
            ACC_BURST: begin
              state_n  = S_BURST;
              bw_start = 1'b1;
              req_n    = (g_len != 9'd0);
            end
            default: begin
              state_n  = S_BURST;
              bw_start = 1'b1;
            end
          endcase
        end
      end
      S_WORD: begin
        if (ram_ack) begin
          req_n   = 1'b0;
          state_n = S_ACK;
          rd_done = ~ram_we;
        end
      end
      S_BURST: begin
        if (bw_empty || (ram_ack && bw_last)) begin
          req_n   = 1'b0;
          state_n = S_ACK;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign gmask = grant ? (gsel ? 2'b10 : 2'b01)
                       : 2'b00;

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= S_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      word_addr <= '0;
      gport     <= 1'b0;
      pend      <= '0;
      ovf_q     <= '0;
      q_addr    <= '0;
      q_din     <= '0;
      q_acc     <= '0;
      q_burst   <= '0;
      rq0_dout  <= '0;
      rq1_dout  <= '0;
    end else begin
      state   <= state_n;
      ram_req <= req_n;
      ovf_q   <= ovf_q | (cs & (pend | active));
      pend    <= want & ~gmask;
      for (int p = 0; p < 2; p++) begin
        if (take[p]) begin
          q_addr[p]  <= in_addr[p];
          q_din[p]   <= in_din[p];
          q_acc[p]   <= in_acc[p];
          q_burst[p] <= in_burst[p];
        end
      end
      if (grant) begin
        gport     <= gsel;
        ram_we    <= (g_acc == ACC_WRITE);
        word_addr <= eff_addr[gsel];
        ram_wdata <= eff_din[gsel];
      end
      if (rd_done && !gport) rq0_dout <= ram_rdata;
      if (rd_done && gport)  rq1_dout <= ram_rdata;
    end
  end

  assign bw_ack = ram_ack && (state == S_BURST);

  mem_arbiter_burst_writer #(
    .HR_AW(HR_AW)
  ) u_bw (
    .clk          (clk),
    .res          (res),
    .start        (bw_start),
    .base         (eff_addr[gsel]),
    .len          (bw_len),
    .word_ack     (bw_ack),
    .rdata        (ram_rdata[15:0]),
    .addr         (bw_addr),
    .empty        (bw_empty),
    .last         (bw_last),
    .high_ram_addr(high_ram_addr),
    .high_ram_din (high_ram_din),
    .high_ram_wr  (high_ram_wr)
  );

  assign ram_addr = (state == S_BURST) ? bw_addr
                                       : word_addr;
  assign rq0_ack  = (state == S_ACK) && !gport;
  assign rq1_ack  = (state == S_ACK) && gport;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter against a
// single-cycle memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] rq0_addr, rq1_addr, rq0_din, rq1_din;
  logic [31:0] rq0_dout, rq1_dout;
  logic        rq0_cs, rq1_cs, rq0_ack, rq1_ack;
  logic [1:0]  rq0_acc, rq1_acc, ovf;
  logic [8:0]  rq0_burst, rq1_burst, high_ram_addr;
  logic        ram_req, ram_we, ram_ack, high_ram_wr;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [15:0] high_ram_din;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .res(res),
    .rq0_addr(rq0_addr), .rq0_cs(rq0_cs),
    .rq0_acc(rq0_acc), .rq0_burst(rq0_burst),
    .rq0_din(rq0_din), .rq0_dout(rq0_dout),
    .rq0_ack(rq0_ack),
    .rq1_addr(rq1_addr), .rq1_cs(rq1_cs),
    .rq1_acc(rq1_acc), .rq1_burst(rq1_burst),
    .rq1_din(rq1_din), .rq1_dout(rq1_dout),
    .rq1_ack(rq1_ack),
    .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .high_ram_addr(high_ram_addr),
    .high_ram_din(high_ram_din),
    .high_ram_wr(high_ram_wr), .ovf(ovf)
  );

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // ack arrives the cycle after each word request
  logic age = 1'b0;
  always @(posedge clk) age <= ram_req && !ram_ack;
  assign ram_ack   = ram_req && age;
  assign ram_rdata = mem_word(ram_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
  } ram_t;
  typedef struct {
    int          p;
    logic [31:0] dout;
    int          cyc;
  } ack_t;
  typedef struct {
    logic [8:0]  addr;
    logic [15:0] din;
    logic        with_ack;
  } hw_t;

  int   rise_q[$];
  ram_t ram_q[$];
  ack_t ack_q[$];
  hw_t  hw_q[$];

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_dout [2];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d",
             name, cyc);
  endtask

  logic prev_req = 1'b0;
  always @(negedge clk) begin : mon
    ack_t a;
    ram_t r;
    hw_t  h;
    if (ram_req && !prev_req) begin
      if (rise_q.size() == 0) unexp("ram_req_rise");
      else chk("ram_req_rise_cycle", 32'(cyc),
               32'(rise_q.pop_front()));
    end
    prev_req = ram_req;
    if (ram_req && ram_ack) begin
      if (ram_q.size() == 0) unexp("ram_access");
      else begin
        r = ram_q.pop_front();
        chk("ram_we", 32'(ram_we), 32'(r.we));
        chk("ram_addr", ram_addr, r.addr);
        if (r.chk_wd) chk("ram_wdata", ram_wdata, r.wdata);
      end
    end
    if (high_ram_wr) begin
      if (hw_q.size() == 0) unexp("high_ram_wr");
      else begin
        h = hw_q.pop_front();
        chk("high_ram_addr", 32'(high_ram_addr),
            32'(h.addr));
        chk("high_ram_din", 32'(high_ram_din),
            32'(h.din));
        chk("hw_ack_coincide", 32'(rq0_ack | rq1_ack),
            32'(h.with_ack));
      end
    end
    if (rq0_ack || rq1_ack) begin
      if (ack_q.size() == 0) unexp("rq_ack");
      else begin
        a = ack_q.pop_front();
        chk("ack_both", 32'(rq0_ack & rq1_ack), 32'd0);
        chk("ack_port", 32'(rq1_ack), 32'(a.p));
        chk("ack_dout", a.p == 1 ? rq1_dout : rq0_dout,
            a.dout);
        chk("ack_cycle", 32'(cyc), 32'(a.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rq0_cs = 1'b0;
    rq1_cs = 1'b0;
  endtask

  task automatic drive(input int p,
                       input logic [1:0] acc,
                       input logic [31:0] addr,
                       input logic [8:0] burst,
                       input logic [31:0] din);
    if (p == 0) begin
      rq0_cs = 1'b1; rq0_acc = acc; rq0_addr = addr;
      rq0_burst = burst; rq0_din = din;
    end else begin
      rq1_cs = 1'b1; rq1_acc = acc; rq1_addr = addr;
      rq1_burst = burst; rq1_din = din;
    end
  endtask

  // g: cycle whose closing edge grants the request
  task automatic exp_word(input int p, input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] din,
                          input int g);
    rise_q.push_back(g + 1);
    ram_q.push_back('{we, addr, din, we});
    if (!we) exp_dout[p] = mem_word(addr);
    ack_q.push_back('{p, exp_dout[p], g + 3});
  endtask

  task automatic exp_burst(input int p,
                           input logic [31:0] addr,
                           input int n, input logic done,
                           input int g);
    logic [31:0] w;
    if (n > 0) rise_q.push_back(g + 1);
    for (int i = 0; i < n; i++) begin
      w = mem_word(addr + 32'(i));
      ram_q.push_back('{1'b0, addr + 32'(i), 32'h0, 1'b0});
      hw_q.push_back('{9'(i), w[15:0],
                       done && (i == n - 1)});
    end
    if (done)
      ack_q.push_back('{p, exp_dout[p],
                        (n == 0) ? g + 2 : g + 2 * n + 1});
  endtask

  task automatic drain();
    int n = 0;
    while ((rise_q.size() + ram_q.size() + ack_q.size()
            + hw_q.size()) != 0 && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) unexp("drain_timeout");
    repeat (3) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rq0_cs = 0; rq0_acc = 0; rq0_addr = 0;
    rq0_burst = 0; rq0_din = 0;
    rq1_cs = 0; rq1_acc = 0; rq1_addr = 0;
    rq1_burst = 0; rq1_din = 0;
    exp_dout[0] = 32'h0;
    exp_dout[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_hr_wr", 32'(high_ram_wr), 32'd0);
    chk("rst_ack", 32'({rq1_ack, rq0_ack}), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_dout0", rq0_dout, 32'd0);
    step();

    // port 1 read and write
    drive(1, ACC_READ, 32'h100, 9'd0, 32'h0);
    c = cyc;
    exp_word(1, 1'b0, 32'h100, 32'h0, c);
    step();
    drain();
    drive(1, ACC_WRITE, 32'h200, 9'd0, 32'hCAFEF00D);
    c = cyc;
    exp_word(1, 1'b1, 32'h200, 32'hCAFEF00D, c);
    step();
    drain();

    // port 0 full-line burst
    drive(0, ACC_BURST, 32'hFDA800, 9'd320, 32'h0);
    c = cyc;
    exp_burst(0, 32'hFDA800, 320, 1'b1, c);
    step();
    drain();

    // simultaneous cs: port 0 first
    drive(0, ACC_READ, 32'h40, 9'd0, 32'h0);
    drive(1, ACC_READ, 32'h80, 9'd0, 32'h0);
    c = cyc;
    exp_word(0, 1'b0, 32'h40, 32'h0, c);
    exp_word(1, 1'b0, 32'h80, 32'h0, c + 3);
    step();
    drain();

    // port 0 waits out a port 1 burst; repeat cs overflows
    drive(1, ACC_BURST, 32'h1000, 9'd320, 32'h0);
    c = cyc;
    exp_burst(1, 32'h1000, 320, 1'b1, c);
    step();
    repeat (9) step();
    drive(0, ACC_READ, 32'h300, 9'd0, 32'h0);
    exp_word(0, 1'b0, 32'h300, 32'h0, c + 641);
    step();
    repeat (9) step();
    drive(0, ACC_READ, 32'h999, 9'd0, 32'h0);
    step();
    chk("ovf_set", 32'(ovf), 32'd1);
    drain();

    // zero-length burst and reserved access
    drive(0, ACC_BURST, 32'h5000, 9'd0, 32'h0);
    c = cyc;
    exp_burst(0, 32'h5000, 0, 1'b1, c);
    step();
    drain();
    drive(1, 2'b11, 32'h6000, 9'd5, 32'h0);
    c = cyc;
    exp_burst(1, 32'h6000, 0, 1'b1, c);
    step();
    drain();

    // oversize burst clamps
    drive(0, ACC_BURST, 32'h2000, 9'd400, 32'h0);
    c = cyc;
    exp_burst(0, 32'h2000, 320, 1'b1, c);
    step();
    drain();

    // reset while word 100 of a burst is outstanding
    drive(1, ACC_BURST, 32'h3000, 9'd320, 32'h0);
    c = cyc;
    exp_burst(1, 32'h3000, 100, 1'b0, c);
    step();
    repeat (49) step();
    drive(0, ACC_READ, 32'h77, 9'd0, 32'h0);
    step();
    repeat (150) step();
    res = 1'b1;
    step();
    res = 1'b0;
    exp_dout[0] = 32'h0;
    exp_dout[1] = 32'h0;
    chk("midrst_ram_req", 32'(ram_req), 32'd0);
    chk("midrst_hr_wr", 32'(high_ram_wr), 32'd0);
    chk("midrst_ack", 32'({rq1_ack, rq0_ack}), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_dout1", rq1_dout, 32'd0);
    repeat (10) step();
    drain();

    // normal service after reset
    drive(1, ACC_READ, 32'h100, 9'd0, 32'h0);
    c = cyc;
    exp_word(1, 1'b0, 32'h100, 32'h0, c);
    step();
    drain();

    repeat (5) step();
    chk("left_rise", 32'(rise_q.size()), 32'd0);
    chk("left_ram", 32'(ram_q.size()), 32'd0);
    chk("left_ack", 32'(ack_q.size()), 32'd0);
    chk("left_hw", 32'(hw_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between two requesters.
  - Port 0 is the video line fetch and always has fixed priority.
  - Port 1 is the CPU / general-purpose master.
- Requesters use the one-cycle `cs` pulse protocol (addr/acc/burst/din, ack).
- The block serialises each request into word accesses on the memory port.
- For `ACC_BURST`, it streams the returned words into the high-RAM line buffer that the VGA controller scans out.

Parameters:
- HR_AW, 9, high-RAM address width; the burst word index wraps modulo 2^HR_AW.
- MAX_BURST, 320, largest legal burst length; larger requests are clamped to this value.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- rq0_addr  in  32  port 0 word address (sampled when rq0_cs=1)
- rq0_cs  in  1  port 0 request strobe, one cycle
- rq0_acc  in  2  port 0 access type
- rq0_burst  in  9  port 0 burst length, in words
- rq0_din  in  32  port 0 write data
- rq0_dout  out  32  port 0 read data, valid with rq0_ack
- rq0_ack  out  1  port 0 completion pulse, one cycle
- rq1_addr, rq1_cs, rq1_acc, rq1_burst, rq1_din, rq1_dout, rq1_ack: same as port 0, for port 1
- ram_req  out  1  memory word request, held until ram_ack
- ram_we  out  1  1 = write
- ram_addr  out  32  memory word address
- ram_wdata  out  32  memory write data
- ram_rdata  in  32  memory read data, valid with ram_ack
- ram_ack  in  1  word done; only legal while ram_req=1
- high_ram_addr  out  9  line-buffer write address
- high_ram_din  out  16  line-buffer write data
- high_ram_wr  out  1  line-buffer write strobe
- ovf  out  2  sticky per port: a cs arrived while that port was already pending or busy

Behaviour:
- Reset:
  - All outputs are driven to 0; state goes to IDLE; both pending latches are cleared.
  - A reset asserted mid-access abandons the access, drops ram_req at the next edge, and issues no ack.
- Pending latches:
  - rq*_cs sets pending[p] and captures addr/acc/burst/din.
  - A cs while pending[p] or active[p] is set is ignored and sets ovf[p].
- Access codes are ACC_READ=00, ACC_WRITE=01, ACC_BURST=10, reserved=11.
- State machine is IDLE, WORD, BURST, ACK.
  - IDLE: grant port 0 if it is pending (including a cs in this same cycle), else port 1.
    - Grant sets ram_req=1 in the cycle after the cs cycle.
    - Grant loads ram_addr from the captured address and ram_we = (acc==WRITE).
    - Grant clears pending for the granted port.
  - WORD (READ/WRITE): hold ram_req, ram_addr and ram_wdata until ram_ack.
    - On the ram_ack edge: drop ram_req, latch ram_rdata into rq*_dout (reads only; writes leave dout unchanged), go to ACK.
  - BURST:
    - On each ram_ack: index k increments, ram_addr increments by 1, and ram_req stays high while words remain.
    - In the cycle after ram_ack, high_ram_wr=1, high_ram_addr=k[HR_AW-1:0], high_ram_din=ram_rdata[15:0].
    - After the last ram_ack, ram_req drops and the state goes to ACK.
  - ACK: rq*_ack=1 for exactly one cycle on the granted port, then IDLE.
    - For bursts, ACK coincides with the final high_ram_wr.
    - The earliest next ram_req is the cycle after ACK.
- Burst length:
  - burst=0: no memory access; ACK follows the grant cycle directly.
  - burst > MAX_BURST is clamped to MAX_BURST.
- Reserved acc: no memory access; acknowledged as in the burst=0 case.
- Arbitration:
  - Port 0 always wins a simultaneous grant.
  - There is no preemption; an active burst on port 1 runs to completion.
- Latency, with a single-cycle memory (ram_ack the cycle after ram_req): WORD ack arrives 3 cycles after cs.

Decomposition:
- Shared header memory_access.vh holds ACC_READ, ACC_WRITE, ACC_BURST and MAX_BURST; it is already included by the VGA controller.
- Sub-module burst_writer holds the word counter and address incrementer and drives the high-RAM write strobe.
  - It is started and stopped by the arbiter FSM.

Test Plan:
- Port 1 READ at address 0x100, memory returns 0xDEADBEEF:
  - ram_req rises one cycle after cs with ram_addr=0x100 and ram_we=0.
  - rq1_ack pulses once with rq1_dout=0xDEADBEEF.
- Port 0 BURST, addr=0xFDA800, burst=320:
  - 320 ram_req handshakes at addresses 0xFDA800..0xFDA93F.
  - high_ram_wr fires 320 times, addr 0..319, din = rdata[15:0].
  - rq0_ack coincides with the write at addr 319.
- Port 0 and port 1 cs in the same cycle:
  - Port 0 is served first.
  - Port 1 ram_req rises the cycle after rq0_ack.
- Port 0 cs during a 320-word port 1 burst:
  - The port 1 burst completes uninterrupted.
  - The port 0 grant follows ACK.
  - A second port 0 cs while port 0 is pending sets ovf[0]=1.
- Edge cases:
  - burst=0: ack two cycles after cs, ram_req never asserted.
  - acc=11: same result as burst=0.
  - burst=400: clamped to 320 words.
- res asserted at burst word 100:
  - The next cycle has ram_req=0, high_ram_wr=0, no ack and pending=0.
  - A new request after reset behaves normally.
